arith_unit_pipe: RTL and testbench



---
 rtl/arith_pkg.sv | 33 +++
 rtl/arith_seq_mult.sv | 74 +++++++
 rtl/arith_unit_pipe.sv | 152 +++++++++++++++
 tb/tb_arith_unit_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the pipelined arithmetic unit: opcodes, FSM states, width helper.
// No logic of its own; imported by the top module and the multiplier core.
// Opcode values keep the legacy 0-7 map and extend it upward.
package arith_pkg;

  // Legacy single-cycle ops
  localparam logic [3:0] OP_INCA  = 4'd0;
  localparam logic [3:0] OP_DECA  = 4'd1;
  localparam logic [3:0] OP_DBLA  = 4'd2;
  localparam logic [3:0] OP_INCB  = 4'd3;
  localparam logic [3:0] OP_DECB  = 4'd4;
  localparam logic [3:0] OP_DBLB  = 4'd5;
  localparam logic [3:0] OP_ADD   = 4'd6;
  localparam logic [3:0] OP_QUADA = 4'd7;
  // Extended ops
  localparam logic [3:0] OP_SUB   = 4'd8;
  localparam logic [3:0] OP_RSUB  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  // Everything at or above this value is rejected with err=1
  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result width: a full signed product of two WIDTH-bit operands
  function automatic int res_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/arith_seq_mult.sv
// Signed WIDTH x WIDTH shift-add multiplier, one partial product per cycle.
// Latency: WIDTH cycles from start; done is high during the last iteration.
// No backpressure: start is only issued while idle, product is valid with done.
module arith_seq_mult
  import arith_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int RES_W = res_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] count;
  logic [RES_W-1:0] addend;
  logic [RES_W-1:0] acc_nx;
  logic             last_iter;

  // The iteration with count==1 handles the multiplier sign bit, whose weight
  // is negative in two's complement, so that partial product is subtracted.
  // This keeps most-negative x most-negative exact.
  assign last_iter = (count == CNT_W'(1));

  // Partial product for the current multiplier bit
  always_comb begin
    addend = '0;
    if (mplier[0]) begin
      addend = last_iter ? (RES_W'(0) - mcand) : mcand;
    end
  end

  assign acc_nx  = acc + addend;
  assign done    = busy && last_iter;
  // The final sum is forwarded combinationally so the product lands on the same
  // edge as the last iteration.
  assign product = acc_nx;

  // Load operands on start, then shift multiplicand left / multiplier right each cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= CNT_W'(WIDTH);
      acc    <= '0;
      mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CNT_W'(1);
      if (last_iter) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/arith_unit_pipe.sv
// Registered arithmetic unit: 10 single-cycle ops plus a sequential signed multiply, with flags.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for multiply; one op in flight.
// Backpressure: result held in DONE until out_ready; in_ready low in MUL and in DONE without out_ready.
module arith_unit_pipe
  import arith_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int RES_W = res_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] res,
  output logic             zero,
  output logic             neg,
  output logic             err
);

  localparam logic [RES_W-1:0] ONE = RES_W'(1);

  state_t state;
  state_t state_nx;

  logic             accept;
  logic             is_mul;
  logic             single_ld;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic             mul_ld;
  logic             res_ld;
  logic [RES_W-1:0] product;

  logic [RES_W-1:0] ext_a;
  logic [RES_W-1:0] ext_b;
  logic [RES_W-1:0] opa;
  logic [RES_W-1:0] opb;
  logic             cin;
  logic             illegal;
  logic [RES_W-1:0] sum;
  logic [RES_W-1:0] single_res;
  logic [RES_W-1:0] res_nx;

  assign ext_a = {{WIDTH{A[WIDTH-1]}}, A};
  assign ext_b = {{WIDTH{B[WIDTH-1]}}, B};

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (sel == OP_MUL);
  assign single_ld = accept && !is_mul;
  assign mul_start = accept && is_mul;
  assign mul_ld    = (state == MUL) && mul_done;

  // Operand steering onto the single shared adder; subtraction uses ~x with carry-in
  always_comb begin
    opa     = '0;
    opb     = '0;
    cin     = 1'b0;
    illegal = 1'b0;
    case (sel)
      OP_INCA:  begin opa = ext_a;      cin = 1'b1; end
      OP_DECA:  begin opa = ext_a;      opb = ~ONE;   cin = 1'b1; end
      OP_DBLA:  begin opa = ext_a;      opb = ext_a; end
      OP_INCB:  begin opa = ext_b;      cin = 1'b1; end
      OP_DECB:  begin opa = ext_b;      opb = ~ONE;   cin = 1'b1; end
      OP_DBLB:  begin opa = ext_b;      opb = ext_b; end
      OP_ADD:   begin opa = ext_a;      opb = ext_b; end
      OP_QUADA: begin opa = ext_a << 1; opb = ext_a << 1; end
      OP_SUB:   begin opa = ext_a;      opb = ~ext_b; cin = 1'b1; end
      OP_RSUB:  begin opa = ext_b;      opb = ~ext_a; cin = 1'b1; end
      default:  illegal = (sel >= OP_ILLEGAL_MIN);
    endcase
  end

  assign sum        = opa + opb + {{(RES_W-1){1'b0}}, cin};
  assign single_res = illegal ? '0 : sum;
  assign res_nx     = single_ld ? single_res : product;
  assign res_ld     = single_ld || mul_ld;

  arith_seq_mult #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: accept from IDLE or straight out of DONE when the result leaves
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = is_mul ? MUL : DONE;
        end
      end
      MUL: begin
        if (mul_done) begin
          state_nx = DONE;
        end else if (!mul_busy) begin
          // Multiplier lost its operation; never present a stale product
          state_nx = IDLE;
        end
      end
      DONE: begin
        if (accept) begin
          state_nx = is_mul ? MUL : DONE;
        end else if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result and flags change together, only when a new result is written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res  <= '0;
      zero <= 1'b0;
      neg  <= 1'b0;
      err  <= 1'b0;
    end else if (res_ld) begin
      res  <= res_nx;
      zero <= (res_nx == '0);
      neg  <= res_nx[RES_W-1];
      err  <= single_ld && illegal;
    end
  end

endmodule

// File: tb/tb_arith_unit_pipe.sv
// Self-checking bench for arith_unit_pipe at WIDTH=4 with a scoreboard queue.
module tb_arith_unit_pipe;

  localparam int WIDTH = 4;
  localparam int RES_W = 2 * WIDTH;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] res;
  logic             zero;
  logic             neg;
  logic             err;

  typedef struct packed {
    logic [RES_W-1:0] res;
    logic             zero;
    logic             neg;
    logic             err;
  } exp_t;

  exp_t             sb[$];
  exp_t             e;
  logic [RES_W+2:0] got;
  int               n_cmp = 0;
  int               n_bad = 0;

  assign got = {res, zero, neg, err};

  arith_unit_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .zero      (zero),
    .neg       (neg),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer math, truncated to RES_W
  function automatic exp_t model(input logic [3:0] s,
                                 input logic signed [WIDTH-1:0] a,
                                 input logic signed [WIDTH-1:0] b);
    exp_t m;
    int ia, ib, r;
    ia = a;
    ib = b;
    case (s)
      4'd0:    r = ia + 1;
      4'd1:    r = ia - 1;
      4'd2:    r = 2 * ia;
      4'd3:    r = ib + 1;
      4'd4:    r = ib - 1;
      4'd5:    r = 2 * ib;
      4'd6:    r = ia + ib;
      4'd7:    r = 4 * ia;
      4'd8:    r = ia - ib;
      4'd9:    r = ib - ia;
      4'd10:   r = ia * ib;
      default: r = 0;
    endcase
    m.res  = r[RES_W-1:0];
    m.zero = (m.res == '0);
    m.neg  = m.res[RES_W-1];
    m.err  = (s >= 4'd11);
    return m;
  endfunction

  task automatic drive(input logic [3:0] s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    in_valid = 1'b1;
    A        = a;
    B        = b;
    sel      = s;
    sb.push_back(model(s, a, b));
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; sel = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, got} !== {1'b1 ^ 1'b1, 1'b1, {(RES_W+3){1'b0}}}) begin
      n_bad++;
      $display("FAIL reset: {out_valid,in_ready,res,z,n,e}=%b required 01_%0d'b0", {out_valid, in_ready, got}, RES_W+3);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_quad_a();
    out_ready = 1'b1;
    drive(4'd7, 4'h8, 4'h0);
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || got !== e) begin
      n_bad++;
      $display("FAIL quad_a: out_valid=%b got=%h required 1 %h", out_valid, got, e);
    end
    n_cmp++;
    if ({res, neg, zero, err} !== {8'hE0, 3'b100}) begin
      n_bad++;
      $display("FAIL quad_a_abs: res=%h n=%b z=%b e=%b required e0 1 0 0", res, neg, zero, err);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL quad_a_dup: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] s;
    out_ready = 1'b1;
    // Plan pair followed by a random single-cycle stream
    for (int i = 0; i <= 22; i++) begin
      if (i > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || got !== e) begin
          n_bad++;
          $display("FAIL b2b[%0d]: out_valid=%b in_ready=%b got=%h required 1 1 %h", i, out_valid, in_ready, got, e);
        end
      end
      if (i == 0) drive(4'd6, 4'd7, 4'd7);
      else if (i == 1) drive(4'd8, 4'd3, 4'd5);
      else if (i < 22) begin
        s = 4'($urandom_range(0, 14));
        if (s >= 4'd10) s = s + 4'd1;
        drive(s, WIDTH'($urandom), WIDTH'($urandom));
      end else in_valid = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_tail: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_mul();
    logic [WIDTH-1:0] ma[8] = '{4'h8, 4'h7, 4'h8, 4'h7, 4'h0, 4'hF, 4'h8, 4'h5};
    logic [WIDTH-1:0] mb[8] = '{4'h8, 4'hD, 4'h7, 4'h7, 4'h5, 4'hF, 4'h1, 4'hA};
    out_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      drive(4'd10, ma[t], mb[t]);
      @(negedge clk);
      for (int k = 1; k <= WIDTH; k++) begin
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL mul_busy[%0d] cyc %0d: in_ready=%b out_valid=%b required 0 0", t, k, in_ready, out_valid);
        end
        // Inputs wiggle while busy and must be ignored
        in_valid = 1'b1;
        A = WIDTH'($urandom);
        B = WIDTH'($urandom);
        sel = 4'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || got !== e) begin
        n_bad++;
        $display("FAIL mul[%0d]: out_valid=%b got=%h required 1 %h", t, out_valid, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(4'd12, 4'd3, 4'd2);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || got !== e || {zero, err} !== 2'b11) begin
      n_bad++;
      $display("FAIL illegal: out_valid=%b got=%h required 1 %h", out_valid, got, e);
    end
    drive(4'd0, 4'd1, 4'd0);
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || got !== e || res !== 8'h02 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL after_illegal: out_valid=%b got=%h required 1 %h", out_valid, got, e);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(4'd6, 4'd3, 4'hE);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || got !== sb[0]) begin
        n_bad++;
        $display("FAIL hold cyc %0d: out_valid=%b in_ready=%b got=%h required 1 0 %h", k, out_valid, in_ready, got, sb[0]);
      end
      in_valid = 1'b1;
      A = WIDTH'($urandom);
      B = WIDTH'($urandom);
      sel = 4'($urandom);
      if (k < 4) @(negedge clk);
    end
    e = sb.pop_front();
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL release_dup: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b1;
    drive(4'd10, 4'd5, 4'hA);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    n_cmp++;
    if ({out_valid, in_ready, got} !== {2'b01, {(RES_W+3){1'b0}}}) begin
      n_bad++;
      $display("FAIL rst_async: {out_valid,in_ready,res,flags}=%b required 01 and zeros", {out_valid, in_ready, got});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, res} !== {2'b01, {RES_W{1'b0}}}) begin
      n_bad++;
      $display("FAIL rst_release: out_valid=%b in_ready=%b res=%h required 0 1 00", out_valid, in_ready, res);
    end
    drive(4'd10, 4'h9, 4'd3);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 10 && out_valid !== 1'b1; k++) @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || got !== e || res !== 8'hEB) begin
      n_bad++;
      $display("FAIL mul_after_rst: out_valid=%b got=%h required 1 %h", out_valid, got, e);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_quad_a();
    test_back_to_back();
    test_mul();
    test_illegal();
    test_backpressure();
    test_reset_mid_mul();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: scoreboard holds %0d entries, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
